// File: rtl/axis_pkg.sv
// Shared types and widths for the AXI4-Stream 64-to-32 downsizer.
// The state enum and half-beat geometry live here so the top and its bench agree.
package axis_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      LO,
      HI
   } state_t;

   localparam int HALF_W      = 32;
   localparam int HALF_KEEP_W = 4;

endpackage

// File: rtl/axis_downsize_64_32.sv
// Splits each 64-bit AXI4-Stream beat into two 32-bit beats, low half first.
// An all-zero upper keep nibble can suppress the upper beat; completed packets are counted.
module axis_downsize_64_32
   import axis_pkg::*;
#(
   parameter bit SKIP_EMPTY_HI = 1'b1,
   parameter int CNT_W         = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [2*HALF_W-1:0]          s_tdata,
   input  logic [2*HALF_KEEP_W-1:0]     s_tkeep,
   input  logic                         s_tlast,
   input  logic                         s_tvalid,
   output logic                         s_tready,
   output logic [HALF_W-1:0]            m_tdata,
   output logic [HALF_KEEP_W-1:0]       m_tkeep,
   output logic                         m_tlast,
   output logic                         m_tvalid,
   input  logic                         m_tready,
   output logic [CNT_W-1:0]             pkt_count
);

   state_t                        state;
   state_t                        state_nx;
   logic [2*HALF_W-1:0]           data_q;
   logic [2*HALF_KEEP_W-1:0]      keep_q;
   logic                          last_q;
   logic                          hi_needed;
   logic                          load;
   logic                          out_fire;

   assign hi_needed = (keep_q[2*HALF_KEEP_W-1:HALF_KEEP_W] != '0) || !SKIP_EMPTY_HI;
   assign out_fire  = m_tvalid && m_tready;

   // Output mux and next state; m_* are driven from registers only, so no s_* path reaches them.
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      s_tready = 1'b0;
      m_tvalid = 1'b0;
      m_tdata  = '0;
      m_tkeep  = '0;
      m_tlast  = 1'b0;
      case (state)
         EMPTY: begin
            s_tready = !reset;
            if (s_tvalid && !reset) begin
               load     = 1'b1;
               state_nx = LO;
            end
         end
         LO: begin
            m_tvalid = 1'b1;
            m_tdata  = data_q[HALF_W-1:0];
            m_tkeep  = keep_q[HALF_KEEP_W-1:0];
            m_tlast  = last_q && !hi_needed;
            s_tready = m_tready && !hi_needed;
            if (m_tready) begin
               if (hi_needed) begin
                  state_nx = HI;
               end else if (s_tvalid) begin
                  load = 1'b1;
               end else begin
                  state_nx = EMPTY;
               end
            end
         end
         HI: begin
            m_tvalid = 1'b1;
            m_tdata  = data_q[2*HALF_W-1:HALF_W];
            m_tkeep  = keep_q[2*HALF_KEEP_W-1:HALF_KEEP_W];
            m_tlast  = last_q;
            s_tready = m_tready;
            if (m_tready) begin
               if (s_tvalid) begin
                  load     = 1'b1;
                  state_nx = LO;
               end else begin
                  state_nx = EMPTY;
               end
            end
         end
         default: begin
            state_nx = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= EMPTY;
         keep_q <= '0;
         last_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (load) begin
            keep_q <= s_tkeep;
            last_q <= s_tlast;
         end
      end
   end

   // Payload is never reset; the mux forces zero on m_tdata while EMPTY.
   always_ff @(posedge clk) begin
      if (load) begin
         data_q <= s_tdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_count <= '0;
      end else if (out_fire && m_tlast) begin
         pkt_count <= pkt_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_axis_downsize_64_32.sv
// Directed bench for axis_downsize_64_32: split order, throughput, partial beats,
// backpressure, reset mid-packet and packet counter wrap (CNT_W=4).
module tb_axis_downsize_64_32;

   logic        clk;
   logic        reset;
   logic [63:0] s_tdata;
   logic [7:0]  s_tkeep;
   logic        s_tlast;
   logic        s_tvalid;
   logic        s_tready;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
   logic        m_tlast;
   logic        m_tvalid;
   logic        m_tready;
   logic [3:0]  pkt_count;

   int n_assert = 0;
   int n_fail   = 0;

   axis_downsize_64_32 #(
      .SKIP_EMPTY_HI(1'b1),
      .CNT_W        (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .s_tdata  (s_tdata),
      .s_tkeep  (s_tkeep),
      .s_tlast  (s_tlast),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .m_tdata  (m_tdata),
      .m_tkeep  (m_tkeep),
      .m_tlast  (m_tlast),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .pkt_count(pkt_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] k, input logic l);
      s_tvalid = v;
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = l;
   endtask

   initial begin
      int          idx;
      int          ocnt;
      int          sent;
      logic        acc;
      logic [31:0] exp_d;

      reset    = 1'b1;
      m_tready = 1'b0;
      drive(1'b0, 64'h0, 8'h00, 1'b0);
      #2;
      chk("rst_tvalid", 64'(m_tvalid), 64'h0);
      chk("rst_tdata", 64'(m_tdata), 64'h0);
      chk("rst_tkeep", 64'(m_tkeep), 64'h0);
      chk("rst_tlast", 64'(m_tlast), 64'h0);
      chk("rst_cnt", 64'(pkt_count), 64'h0);
      chk("rst_tready", 64'(s_tready), 64'h0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("post_rst_tready", 64'(s_tready), 64'h1);

      // Single full beat
      m_tready = 1'b1;
      drive(1'b1, 64'h1111_2222_3333_4444, 8'hFF, 1'b1);
      tick();
      drive(1'b0, 64'h0, 8'h00, 1'b0);
      #1;
      chk("sb_lo_valid", 64'(m_tvalid), 64'h1);
      chk("sb_lo_data", 64'(m_tdata), 64'h3333_4444);
      chk("sb_lo_last", 64'(m_tlast), 64'h0);
      chk("sb_lo_keep", 64'(m_tkeep), 64'hF);
      chk("sb_lo_ready", 64'(s_tready), 64'h0);
      tick();
      chk("sb_hi_data", 64'(m_tdata), 64'h1111_2222);
      chk("sb_hi_last", 64'(m_tlast), 64'h1);
      chk("sb_hi_ready", 64'(s_tready), 64'h1);
      chk("sb_hi_cnt", 64'(pkt_count), 64'h0);
      tick();
      chk("sb_end_valid", 64'(m_tvalid), 64'h0);
      chk("sb_end_data", 64'(m_tdata), 64'h0);
      chk("sb_cnt", 64'(pkt_count), 64'h1);

      // Eight back-to-back full beats: 16 outputs without bubbles
      idx  = 0;
      ocnt = 0;
      for (int c = 0; c < 18; c++) begin
         drive(idx < 8, {32'hA000_0000 + 32'(2 * idx + 1), 32'hA000_0000 + 32'(2 * idx)},
               8'hFF, idx == 7);
         #1;
         if (c <= 16) chk("b2b_ready", 64'(s_tready), 64'((c % 2) == 0));
         if (c >= 1 && c <= 16) begin
            exp_d = 32'hA000_0000 + 32'(ocnt);
            chk("b2b_valid", 64'(m_tvalid), 64'h1);
            chk("b2b_data", 64'(m_tdata), 64'(exp_d));
            chk("b2b_last", 64'(m_tlast), 64'(ocnt == 15));
            ocnt++;
         end
         acc = s_tvalid && s_tready;
         tick();
         if (acc) idx++;
      end
      drive(1'b0, 64'h0, 8'h00, 1'b0);
      #1;
      chk("b2b_accepted", 64'(idx), 64'd8);
      chk("b2b_end_valid", 64'(m_tvalid), 64'h0);
      chk("b2b_cnt", 64'(pkt_count), 64'h2);

      // Partial last beat, next beat accepted in the same cycle
      drive(1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 1'b1);
      tick();
      drive(1'b1, 64'h5555_6666_7777_8888, 8'hFF, 1'b1);
      #1;
      chk("pl_data", 64'(m_tdata), 64'hCAFE_F00D);
      chk("pl_keep", 64'(m_tkeep), 64'hF);
      chk("pl_last", 64'(m_tlast), 64'h1);
      chk("pl_ready", 64'(s_tready), 64'h1);
      tick();
      drive(1'b0, 64'h0, 8'h00, 1'b0);
      #1;
      chk("pl_cnt", 64'(pkt_count), 64'h3);
      chk("pl_next_lo", 64'(m_tdata), 64'h7777_8888);
      chk("pl_next_lo_last", 64'(m_tlast), 64'h0);
      tick();
      chk("pl_next_hi", 64'(m_tdata), 64'h5555_6666);
      chk("pl_next_hi_last", 64'(m_tlast), 64'h1);
      tick();
      chk("pl_end_cnt", 64'(pkt_count), 64'h4);

      // keep=0 with last=1: low half still carries the boundary
      drive(1'b1, 64'h9999_AAAA_BBBB_CCCC, 8'h00, 1'b1);
      tick();
      drive(1'b0, 64'h0, 8'h00, 1'b0);
      #1;
      chk("k0_data", 64'(m_tdata), 64'hBBBB_CCCC);
      chk("k0_keep", 64'(m_tkeep), 64'h0);
      chk("k0_last", 64'(m_tlast), 64'h1);
      tick();
      chk("k0_valid", 64'(m_tvalid), 64'h0);
      chk("k0_cnt", 64'(pkt_count), 64'h5);

      // Backpressure for 5 cycles while the low half is presented
      drive(1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
      tick();
      m_tready = 1'b0;
      drive(1'b1, 64'hFEDC_BA98_7654_3210, 8'hF0, 1'b1);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_data", 64'(m_tdata), 64'h89AB_CDEF);
         chk("bp_keep", 64'(m_tkeep), 64'hF);
         chk("bp_last", 64'(m_tlast), 64'h0);
         chk("bp_ready", 64'(s_tready), 64'h0);
         tick();
      end
      m_tready = 1'b1;
      #1;
      chk("bp_resume_lo", 64'(m_tdata), 64'h89AB_CDEF);
      chk("bp_resume_ready", 64'(s_tready), 64'h0);
      tick();
      chk("bp_hi_data", 64'(m_tdata), 64'h0123_4567);
      chk("bp_hi_last", 64'(m_tlast), 64'h1);
      chk("bp_hi_ready", 64'(s_tready), 64'h1);
      tick();
      drive(1'b0, 64'h0, 8'h00, 1'b0);
      #1;
      chk("f0_lo_data", 64'(m_tdata), 64'h7654_3210);
      chk("f0_lo_keep", 64'(m_tkeep), 64'h0);
      chk("f0_lo_last", 64'(m_tlast), 64'h0);
      tick();
      chk("f0_hi_data", 64'(m_tdata), 64'hFEDC_BA98);
      chk("f0_hi_keep", 64'(m_tkeep), 64'hF);
      tick();
      chk("bp_cnt", 64'(pkt_count), 64'h7);

      // Reset while the upper half is pending
      drive(1'b1, 64'h1357_9BDF_2468_ACE0, 8'hFF, 1'b1);
      tick();
      drive(1'b0, 64'h0, 8'h00, 1'b0);
      tick();
      chk("mr_hi_valid", 64'(m_tvalid), 64'h1);
      chk("mr_hi_data", 64'(m_tdata), 64'h1357_9BDF);
      reset = 1'b1;
      #1;
      chk("mr_valid", 64'(m_tvalid), 64'h0);
      chk("mr_cnt", 64'(pkt_count), 64'h0);
      chk("mr_ready", 64'(s_tready), 64'h0);
      chk("mr_data", 64'(m_tdata), 64'h0);
      tick();
      reset = 1'b0;
      #1;
      chk("mr_rel_ready", 64'(s_tready), 64'h1);
      drive(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 1'b1);
      tick();
      drive(1'b0, 64'h0, 8'h00, 1'b0);
      #1;
      chk("mr_new_lo", 64'(m_tdata), 64'hCCCC_DDDD);
      tick();
      chk("mr_new_hi", 64'(m_tdata), 64'hAAAA_BBBB);
      chk("mr_new_last", 64'(m_tlast), 64'h1);
      tick();
      chk("mr_new_cnt", 64'(pkt_count), 64'h1);

      // Counter wrap: 17 single-half packets from zero, one per cycle
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sent  = 0;
      for (int c = 0; c < 40 && sent < 17; c++) begin
         drive(1'b1, {32'h0, 32'(c)}, 8'h0F, 1'b1);
         #1;
         if (s_tready) sent++;
         tick();
      end
      drive(1'b0, 64'h0, 8'h00, 1'b0);
      #1;
      chk("wrap_sent", 64'(sent), 64'd17);
      chk("wrap_last_data", 64'(m_tdata), 64'd16);
      chk("wrap_pre_cnt", 64'(pkt_count), 64'h0);
      tick();
      chk("wrap_valid", 64'(m_tvalid), 64'h0);
      chk("wrap_cnt", 64'(pkt_count), 64'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_downsize_64_32.md
Name: axis_downsize_64_32

Overview:
- AXI4-Stream width converter that splits 64-bit beats into two 32-bit beats.
- Mirror of the 32-to-64 upsizer on the ingress path. Sits between the encoder output stream (data/last/valid/ready) and the 32-bit S2MM DMA port of the reconfigurable partition.
- Replaces the vendor 64-to-32 IP. Adds tkeep-based half-beat suppression and a packet counter for debug.

Parameters:
- SKIP_EMPTY_HI, 1, when 1 the upper half is not emitted if its tkeep nibble is 0; when 0 both halves are always emitted.
- CNT_W, 16, width of the packet counter.

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- s_tdata  in  64  input beat; bits [31:0] are emitted first
- s_tkeep  in  8  byte enables; [3:0] belong to the low half, [7:4] to the high half
- s_tlast  in  1  last beat of the packet
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- m_tdata  out  32  output beat
- m_tkeep  out  4  output byte enables
- m_tlast  out  1  last output beat of the packet
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- pkt_count  out  CNT_W  count of completed output packets; wraps

Behaviour:
- Storage: data_q[63:0], keep_q[7:0], last_q, plus a state register.
- States: EMPTY, LO, HI.
- Reset:
  - While reset is high: state=EMPTY, m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, pkt_count=0, s_tready=0.
  - After reset deasserts, s_tready=1 in EMPTY.
- hi_needed = (keep_q[7:4]!=0) || !SKIP_EMPTY_HI.
- Output mux:
  - m_tvalid = (state!=EMPTY).
  - LO: m_tdata=data_q[31:0], m_tkeep=keep_q[3:0], m_tlast=last_q && !hi_needed.
  - HI: m_tdata=data_q[63:32], m_tkeep=keep_q[7:4], m_tlast=last_q.
- Handshakes:
  - s_tready: 1 in EMPTY; m_tready && !hi_needed in LO; m_tready in HI.
  - s_tready may depend combinationally on m_tready.
  - m_tvalid and m_* must never depend combinationally on any s_* input.
- Transitions (acc = s_tvalid && s_tready; out = m_tvalid && m_tready):
  - EMPTY: on acc, load the registers and go to LO. Input-to-output latency is 1 cycle.
  - LO, on out: if hi_needed, go to HI; else if acc, reload and stay LO; else go to EMPTY.
  - HI, on out: if acc, reload and go to LO; else go to EMPTY.
  - Without out, the state and registers hold. m_* stays stable while m_tvalid=1 && !m_tready (AXIS rule).
- Throughput:
  - Full 64-bit beats: one input beat per 2 cycles, continuous 32-bit output with no bubbles.
  - Upper-empty beats (SKIP_EMPTY_HI=1): one input beat per cycle.
- The low half is always emitted, even when keep[3:0]=0. This preserves the packet boundary when the input beat has keep=0 and last=1.
- The upper nibble is not checked for contiguity; it is passed through as-is.
- pkt_count increments by 1 on every out with m_tlast=1, and wraps from 2^CNT_W-1 to 0.
- Reset mid-packet: buffered halves are discarded and no tlast is emitted. Downstream sees a truncated packet, and recovery is the DMA's responsibility.
- X-safety: data_q is not reset-qualified for functional purposes, but m_tdata must read 0 in EMPTY.

Decomposition:
- Shared package axis_pkg:
  - typedef for the state enum (EMPTY, LO, HI).
  - Localparams for the half width (32) and the half keep width (4).
- No sub-module needed. The control logic fits one always_ff block plus a combinational output mux.

Test Plan:
- Single beat: s_tdata=64'h1111_2222_3333_4444, keep=8'hFF, last=1, m_tready=1 -> next cycles output 32'h3333_4444 (last=0), then 32'h1111_2222 (last=1); pkt_count=1.
- Back-to-back: 8 full beats, m_tready=1 -> 16 contiguous output beats. s_tready toggles 1,0,1,0; no bubble on m_tvalid.
- Partial last: beat keep=8'h0F, last=1, data=64'hDEAD_BEEF_CAFE_F00D -> one output beat 32'hCAFE_F00D, keep=4'hF, last=1. A following beat is accepted in the same cycle.
- Backpressure: hold m_tready=0 for 5 cycles mid-beat -> m_tdata/m_tkeep/m_tlast stable and s_tready=0 throughout; output resumes correctly when m_tready returns.
- Reset mid-packet: assert reset while in HI -> m_tvalid=0 in the same cycle, pkt_count=0. After release, a new packet passes cleanly.
- Counter wrap: CNT_W=4, send 17 single-beat packets -> pkt_count reads 1.
